// File: rtl/sl_pkg.sv
// Shared definitions for the SL bridge/arbiter codebase.
// Contents: word layout (SL_WORD_W, HMB/LMB modifier field bounds), modifier codes,
// arbiter FSM state type and a helper that assembles a tagged word.
package sl_pkg;

    localparam int unsigned SL_WORD_W = 34;
    localparam int unsigned HMB       = 33;  // high bit of the modifier field
    localparam int unsigned LMB       = 32;  // low bit of the modifier field

    localparam logic [1:0] CONFIG_MODIFIER  = 2'd0;
    localparam logic [1:0] DATA_MODIFIER    = 2'd1;
    localparam logic [1:0] STATUS_MODIFIER  = 2'd2;
    localparam logic [1:0] CHANNEL_MODIFIER = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StMarker,
        StData,
        StHold
    } arb_state_e;

    function automatic logic [SL_WORD_W-1:0] sl_make_word(input logic [1:0]  modifier,
                                                          input logic [31:0] payload);
        logic [SL_WORD_W-1:0] w;
        w            = '0;
        w[HMB:LMB]   = modifier;
        w[LMB-1:0]   = payload;
        return w;
    endfunction

endpackage

// File: rtl/sl_rr_picker.sv
// Combinational round-robin picker.
// Ports:
//   req   - request vector, one bit per source
//   ptr   - last granted index; search starts at ptr+1 and wraps modulo N_SRC
//   grant - first requesting index found in search order
//   found - at least one request is set
module sl_rr_picker #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned SRC_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [SRC_W-1:0] ptr,
    output logic [SRC_W-1:0] grant,
    output logic             found
);

    logic [SRC_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        // Walk from the farthest offset to the nearest so the nearest requester wins.
        for (int off = int'(N_SRC); off >= 1; off--) begin
            idx = SRC_W'((int'(ptr) + off) % int'(N_SRC));
            if (req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sl_fifo_arbiter.sv
// Merges N_SRC bridge response streams into the single 34-bit host write FIFO.
// Round-robin grant with bounded bursts; a CHANNEL-modifier marker word is emitted
// whenever the emitting source changes (and after reset).
// Optional build macro: SL_ARB_PRIO0_EN - source 0 gets strict priority and may
// truncate another source's burst.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   src_valid        - source i holds a word
//   src_data         - source i word at [34*i+33:34*i]
//   src_ready        - one-cycle pop pulse to the granted source
//   fifo_write_full  - write FIFO full
//   fifo_write_data  - registered word to the FIFO
//   fifo_write_inc   - one-cycle write pulse
//   cur_src          - currently granted source index
//   busy             - FSM not idle
module sl_fifo_arbiter
    import sl_pkg::*;
#(
    parameter int unsigned N_SRC     = 4,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned SRC_W     = $clog2(N_SRC)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_SRC-1:0]           src_valid,
    input  logic [SL_WORD_W*N_SRC-1:0] src_data,
    output logic [N_SRC-1:0]           src_ready,
    input  logic                       fifo_write_full,
    output logic [SL_WORD_W-1:0]       fifo_write_data,
    output logic                       fifo_write_inc,
    output logic [SRC_W-1:0]           cur_src,
    output logic                       busy
);

    arb_state_e           state_q, state_d;
    logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]     last_src_q, last_src_d;
    logic                 last_valid_q, last_valid_d;
    logic [7:0]           burst_cnt_q, burst_cnt_d;
    logic [SRC_W-1:0]     cur_src_q, cur_src_d;
    logic [SL_WORD_W-1:0] wdata_q, wdata_d;
    logic                 winc_q, winc_d;
    logic [N_SRC-1:0]     ready_q, ready_d;

    logic [SL_WORD_W-1:0] words [N_SRC];
    logic [SRC_W-1:0]     rr_grant;
    logic                 rr_found;
    logic [SRC_W-1:0]     idle_grant;
    logic                 idle_found;
    logic                 truncate;

    always_comb begin
        for (int i = 0; i < int'(N_SRC); i++) begin
            words[i] = src_data[SL_WORD_W*i +: SL_WORD_W];
        end
    end

    sl_rr_picker #(
        .N_SRC (N_SRC),
        .SRC_W (SRC_W)
    ) u_rr_picker (
        .req   (src_valid),
        .ptr   (rr_ptr_q),
        .grant (rr_grant),
        .found (rr_found)
    );

`ifdef SL_ARB_PRIO0_EN
    logic [SRC_W-1:0] prio_grant;
    logic             prio_found;

    // Only bit 0 survives the mask; starting the search at 0 makes it resolve to 0.
    sl_rr_picker #(
        .N_SRC (N_SRC),
        .SRC_W (SRC_W)
    ) u_prio_picker (
        .req   (src_valid & N_SRC'(1)),
        .ptr   (SRC_W'(N_SRC - 1)),
        .grant (prio_grant),
        .found (prio_found)
    );

    assign idle_grant = prio_found ? prio_grant : rr_grant;
    assign idle_found = rr_found;
    assign truncate   = (cur_src_q != '0) && src_valid[0];
`else
    assign idle_grant = rr_grant;
    assign idle_found = rr_found;
    assign truncate   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            rr_ptr_q     <= SRC_W'(N_SRC - 1);
            last_src_q   <= '0;
            last_valid_q <= 1'b0;
            burst_cnt_q  <= '0;
            cur_src_q    <= '0;
            wdata_q      <= '0;
            winc_q       <= 1'b0;
            ready_q      <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            last_src_q   <= last_src_d;
            last_valid_q <= last_valid_d;
            burst_cnt_q  <= burst_cnt_d;
            cur_src_q    <= cur_src_d;
            wdata_q      <= wdata_d;
            winc_q       <= winc_d;
            ready_q      <= ready_d;
        end
    end

    // Next state
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        last_src_d   = last_src_q;
        last_valid_d = last_valid_q;
        burst_cnt_d  = burst_cnt_q;
        cur_src_d    = cur_src_q;
        wdata_d      = wdata_q;
        winc_d       = 1'b0;
        ready_d      = '0;

        unique case (state_q)
            StIdle: begin
                if (idle_found) begin
                    cur_src_d   = idle_grant;
                    burst_cnt_d = '0;
                    if (!last_valid_q || (idle_grant != last_src_q)) begin
                        state_d = StMarker;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StMarker: begin
                if (!fifo_write_full) begin
                    wdata_d      = sl_make_word(CHANNEL_MODIFIER, 32'(cur_src_q));
                    winc_d       = 1'b1;
                    last_src_d   = cur_src_q;
                    last_valid_d = 1'b1;
                    state_d      = StData;
                end
            end
            StData: begin
                if (!src_valid[cur_src_q]) begin
                    rr_ptr_d = cur_src_q;
                    state_d  = StIdle;
                end else if (!fifo_write_full) begin
                    wdata_d            = words[cur_src_q];
                    winc_d             = 1'b1;
                    ready_d[cur_src_q] = 1'b1;
                    burst_cnt_d        = burst_cnt_q + 8'd1;
                    state_d            = StHold;
                end
            end
            StHold: begin
                // Source updates valid/data during this cycle; DATA re-evaluates next.
                if ((burst_cnt_q == 8'(MAX_BURST)) || truncate) begin
                    rr_ptr_d = cur_src_q;
                    state_d  = StIdle;
                end else begin
                    state_d = StData;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        src_ready       = ready_q;
        fifo_write_data = wdata_q;
        fifo_write_inc  = winc_q;
        cur_src         = cur_src_q;
        busy            = (state_q != StIdle);
    end

endmodule

// File: tb/tb_sl_fifo_arbiter.sv
// Self-checking bench for sl_fifo_arbiter (N_SRC=4, MAX_BURST=8).
// Source queues model the bridges: valid/data track the queue head and the head is
// dropped on each src_ready pulse. Every FIFO write is captured and compared with
// hand-built expected sequences.
module tb_sl_fifo_arbiter;
    import sl_pkg::*;

    localparam int N  = 4;
    localparam int MB = 8;

    logic                   clk;
    logic                   rst_n;
    logic [N-1:0]           src_valid;
    logic [SL_WORD_W*N-1:0] src_data;
    logic [N-1:0]           src_ready;
    logic                   fifo_write_full;
    logic [SL_WORD_W-1:0]   fifo_write_data;
    logic                   fifo_write_inc;
    logic [1:0]             cur_src;
    logic                   busy;

    int checks = 0;
    int errors = 0;

    logic [33:0] srcq [N][$];
    logic [33:0] cap[$];
    logic [33:0] exp_q[$];
    int          pops [N];
    logic        full_prev;

    typedef struct {
        logic [3:0] mask;
        logic [1:0] first_src;
        logic [1:0] last_src;
        int         nwords;
    } vec_t;
    vec_t vecs [7];

    sl_fifo_arbiter #(
        .N_SRC     (N),
        .MAX_BURST (MB)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .src_valid       (src_valid),
        .src_data        (src_data),
        .src_ready       (src_ready),
        .fifo_write_full (fifo_write_full),
        .fifo_write_data (fifo_write_data),
        .fifo_write_inc  (fifo_write_inc),
        .cur_src         (cur_src),
        .busy            (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        full_prev = 1'b0;
        forever begin
            @(posedge clk);
            full_prev = fifo_write_full;
        end
    end

    function automatic logic [33:0] marker(input int s);
        return {2'b11, 32'(s)};
    endfunction

    function automatic logic [33:0] dword(input int s, input int k);
        return {2'b01, 32'((s << 16) | k)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            src_valid[i] = (srcq[i].size() != 0);
            src_data[SL_WORD_W*i +: SL_WORD_W] = (srcq[i].size() != 0) ? srcq[i][0] : '0;
        end
    endtask

    task automatic push(input int s, input logic [33:0] w);
        srcq[s].push_back(w);
        refresh();
    endtask

    // Capture writes, check pulse invariants, then model the source pops.
    initial begin
        logic [33:0] junk;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (fifo_write_inc) begin
                    cap.push_back(fifo_write_data);
                    checks++;
                    if (full_prev) begin
                        errors++;
                        $display("FAIL inc_while_full actual=1 required=0");
                    end
                end
                if (src_ready != '0) begin
                    checks++;
                    if (!$onehot(src_ready) || !fifo_write_inc) begin
                        errors++;
                        $display("FAIL ready_pulse actual=%b/inc=%b required=onehot/inc=1",
                                 src_ready, fifo_write_inc);
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (src_ready[i] && srcq[i].size() != 0) begin
                    junk = srcq[i].pop_front();
                    pops[i]++;
                end
            end
            refresh();
        end
    end

    task automatic do_reset();
        rst_n           = 1'b0;
        fifo_write_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            srcq[i].delete();
            pops[i] = 0;
        end
        refresh();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cap.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle(input string name);
        int stable = 0;
        int n      = 0;
        while (stable < 3 && n < 2000) begin
            @(negedge clk);
            n++;
            if (!busy && src_valid == '0) stable++;
            else stable = 0;
        end
        if (stable < 3) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=busy%0b required=idle", name, busy);
        end
    endtask

    task automatic check_seq(input string name);
        chk({name, "_len"}, 64'(cap.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            chk($sformatf("%s[%0d]", name, i), 64'(cap[i]), 64'(exp_q[i]));
        end
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [33:0] w;
        int          n;
        int          stall_bad;

        vecs[0] = '{4'b0100, 2'd2, 2'd2, 2};
        vecs[1] = '{4'b1010, 2'd1, 2'd3, 4};
        vecs[2] = '{4'b1000, 2'd3, 2'd3, 2};
        vecs[3] = '{4'b0001, 2'd0, 2'd0, 2};
        vecs[4] = '{4'b1111, 2'd0, 2'd3, 8};
        vecs[5] = '{4'b1100, 2'd2, 2'd3, 4};
        vecs[6] = '{4'b0110, 2'd1, 2'd2, 4};

        rst_n           = 1'b0;
        fifo_write_full = 1'b0;
        src_valid       = '0;
        src_data        = '0;
        for (int i = 0; i < N; i++) pops[i] = 0;
        #1;
        chk("rst_src_ready", 64'(src_ready), 64'(0));
        chk("rst_inc", 64'(fifo_write_inc), 64'(0));
        chk("rst_data", 64'(fifo_write_data), 64'(0));
        chk("rst_cur_src", 64'(cur_src), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));

        // Grant order from reset (rr_ptr = 3): one word per requesting source.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            for (int s = 0; s < N; s++) begin
                if (vecs[v].mask[s]) push(s, dword(s, 100 + v));
            end
            wait_idle($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_len", v), 64'(cap.size()), 64'(vecs[v].nwords));
            w = (cap.size() > 0) ? cap[0] : '0;
            chk($sformatf("vec%0d_first", v), 64'(w), 64'(marker(int'(vecs[v].first_src))));
            w = (cap.size() >= 2) ? cap[cap.size() - 2] : '0;
            chk($sformatf("vec%0d_last", v), 64'(w), 64'(marker(int'(vecs[v].last_src))));
        end

        // Plan 1: two words from source 2.
        do_reset();
        push(2, 34'h1_A5A5_0001);
        push(2, 34'h1_A5A5_0002);
        wait_idle("t1");
        exp_q.push_back(34'h3_0000_0002);
        exp_q.push_back(34'h1_A5A5_0001);
        exp_q.push_back(34'h1_A5A5_0002);
        check_seq("t1");
        chk("t1_pops", 64'(pops[2]), 64'(2));
        chk("t1_busy", 64'(busy), 64'(0));

        // Plan 2: burst limit with two competing sources.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            push(0, dword(0, k));
            push(1, dword(1, k));
        end
        wait_idle("t2");
`ifdef SL_ARB_PRIO0_EN
        exp_q.push_back(marker(0));
        for (int k = 0; k < 10; k++) exp_q.push_back(dword(0, k));
        exp_q.push_back(marker(1));
        for (int k = 0; k < 10; k++) exp_q.push_back(dword(1, k));
`else
        exp_q.push_back(marker(0));
        for (int k = 0; k < 8; k++) exp_q.push_back(dword(0, k));
        exp_q.push_back(marker(1));
        for (int k = 0; k < 8; k++) exp_q.push_back(dword(1, k));
        exp_q.push_back(marker(0));
        for (int k = 8; k < 10; k++) exp_q.push_back(dword(0, k));
        exp_q.push_back(marker(1));
        for (int k = 8; k < 10; k++) exp_q.push_back(dword(1, k));
`endif
        check_seq("t2");

        // Plan 3: FIFO full for 5 cycles while in DATA.
        do_reset();
        push(1, dword(1, 0));
        push(1, dword(1, 1));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fifo_write_inc && n < 50);
        chk("t3_marker_seen", 64'(fifo_write_inc), 64'(1));
        fifo_write_full = 1'b1;
        stall_bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (fifo_write_inc || src_ready != '0) stall_bad++;
        end
        chk("t3_stall_quiet", 64'(stall_bad), 64'(0));
        fifo_write_full = 1'b0;
        wait_idle("t3");
        exp_q.push_back(marker(1));
        exp_q.push_back(dword(1, 0));
        exp_q.push_back(dword(1, 1));
        check_seq("t3");
        chk("t3_pops", 64'(pops[1]), 64'(2));

        // Plan 4: same source across an idle gap needs only one marker.
        do_reset();
        for (int k = 0; k < 3; k++) push(3, dword(3, k));
        wait_idle("t4a");
        for (int k = 3; k < 6; k++) push(3, dword(3, k));
        wait_idle("t4b");
        exp_q.push_back(marker(3));
        for (int k = 0; k < 6; k++) exp_q.push_back(dword(3, k));
        check_seq("t4");

        // Plan 5: reset during HOLD.
        do_reset();
        for (int k = 0; k < 3; k++) push(2, dword(2, k));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (src_ready[2] !== 1'b1 && n < 50);
        chk("t5_hold_seen", 64'(src_ready[2]), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ready", 64'(src_ready), 64'(0));
        chk("t5_rst_inc", 64'(fifo_write_inc), 64'(0));
        chk("t5_rst_data", 64'(fifo_write_data), 64'(0));
        chk("t5_rst_cur_src", 64'(cur_src), 64'(0));
        chk("t5_rst_busy", 64'(busy), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_idle("t5");
        exp_q.push_back(marker(2));
        exp_q.push_back(dword(2, 0));
        exp_q.push_back(marker(2));
        exp_q.push_back(dword(2, 1));
        exp_q.push_back(dword(2, 2));
        check_seq("t5");

`ifdef SL_ARB_PRIO0_EN
        // Plan 6: source 0 interrupts a source-1 burst after its current word.
        do_reset();
        for (int k = 0; k < 6; k++) push(1, dword(1, k));
        n = 0;
        stall_bad = 0;
        while (stall_bad < 2 && n < 100) begin
            @(negedge clk);
            n++;
            if (src_ready[1]) stall_bad++;
        end
        chk("t6_pops_before", 64'(stall_bad), 64'(2));
        push(0, dword(0, 0));
        push(0, dword(0, 1));
        wait_idle("t6");
        exp_q.push_back(marker(1));
        exp_q.push_back(dword(1, 0));
        exp_q.push_back(dword(1, 1));
        exp_q.push_back(marker(0));
        exp_q.push_back(dword(0, 0));
        exp_q.push_back(dword(0, 1));
        exp_q.push_back(marker(1));
        for (int k = 2; k < 6; k++) exp_q.push_back(dword(1, k));
        check_seq("t6");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sl_fifo_arbiter.md
Name: sl_fifo_arbiter

Overview:
Merges response streams from N_SRC per-channel FIFO bridges into the single 34-bit host-bound write FIFO.
- Arbitration: round-robin, with a bounded burst per grant.
- Source tagging: inserts a CHANNEL-modifier marker word whenever the emitting source changes, so the host can attribute each following CONFIG/DATA/STATUS word.
- Placement: sits between the bridges' output ports and the async write FIFO.

Parameters:
N_SRC, 4, number of requesting bridges (2..16).
MAX_BURST, 8, maximum data words popped per grant before re-arbitration (1..255).
SRC_W, $clog2(N_SRC), width of the source index.

Ports:
clk  in  1  clock.
rst_n  in  1  reset, asynchronous, active-low.
src_valid  in  N_SRC  source i holds a word.
src_data  in  34*N_SRC  word of source i at bits [34*i+33:34*i]; [33:32] modifier, [31:0] payload.
src_ready  out  N_SRC  one-cycle pop pulse to source i.
fifo_write_full  in  1  write FIFO full.
fifo_write_data  out  34  registered word to FIFO.
fifo_write_inc  out  1  one-cycle write pulse.
cur_src  out  SRC_W  currently granted source index.
busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values:
  - src_ready=0, fifo_write_data=0, fifo_write_inc=0, cur_src=0, busy=0.
  - Internal: rr_ptr=N_SRC-1, last_src=0, last_valid=0, burst_cnt=0, state=IDLE.
- Reset asserted mid-operation aborts at once. The word in flight is not written. last_valid=0, so the next output is preceded by a marker.
- FSM states: IDLE, MARKER, DATA, HOLD.
- IDLE:
  - If any src_valid is high, grant g = first valid index searching rr_ptr+1, rr_ptr+2, ... modulo N_SRC.
  - Latch cur_src=g and clear burst_cnt.
  - Go to MARKER if !last_valid or g!=last_src; otherwise go to DATA.
  - With no requests, remain in IDLE.
- MARKER:
  - Waits while fifo_write_full.
  - Otherwise: fifo_write_data<={2'd3, 32'(g)}, fifo_write_inc<=1 for one cycle, last_src<=g, last_valid<=1, then go to DATA.
- DATA (evaluated in the cycle after MARKER/HOLD):
  - If src_valid[g]=0, go to IDLE and set rr_ptr<=g.
  - Else if fifo_write_full, wait (the grant is retained).
  - Else, at the next edge: fifo_write_data<=src_data[g], fifo_write_inc<=1, src_ready[g]<=1, burst_cnt++, go to HOLD.
- HOLD:
  - fifo_write_inc and src_ready are high for exactly this one cycle.
  - Purpose: gives the source one cycle to update valid/data after the pop.
  - Next state: IDLE with rr_ptr<=g if burst_cnt==MAX_BURST; otherwise DATA.
- Timing and ordering:
  - Throughput is one data word per 2 cycles.
  - Marker-to-first-data latency is 1 cycle.
  - The data word leaves in the same cycle as its pop pulse.
- Source data is forwarded unmodified; modifiers are not checked.
- At most one src_ready bit is ever high. fifo_write_inc is never high while fifo_write_full was high at the decision edge.
- Burst expiry with only g still valid: g is re-granted immediately and no marker is emitted.
- Simultaneous requests: strict rotation from rr_ptr+1, so no source waits more than N_SRC-1 grants.

Optional Feature:
SL_ARB_PRIO0_EN
- Defined: source 0 carries control responses and has strict priority.
  - In IDLE, src_valid[0] wins regardless of rr_ptr.
  - In HOLD, if g!=0 and src_valid[0]=1, the burst is truncated: go to IDLE, set rr_ptr<=g.
  - A marker precedes the switch as normal.
- Undefined: pure round-robin; source 0 is treated like the others.

Decomposition:
- Shared package sl_pkg holds:
  - Modifier constants: CONFIG_MODIFIER=2'd0, DATA_MODIFIER=2'd1, STATUS_MODIFIER=2'd2, CHANNEL_MODIFIER=2'd3.
  - HMB=33, LMB=32, SL_WORD_W=34.
  - Arbiter state enum.
- The bridges reuse the same package.
- One sub-module is natural: sl_rr_picker. It is combinational; inputs are a request vector and a pointer, outputs are the granted index and a found flag. It is reused by the SL_ARB_PRIO0_EN path with a masked request vector.

Test Plan:
1. After reset, src_valid=4'b0100, src2 holds 2 words {1,0xA5A5_0001},{1,0xA5A5_0002} -> FIFO receives {3,0x2}, {1,0xA5A5_0001}, {1,0xA5A5_0002}; 2 src_ready[2] pulses; busy back to 0.
2. src0 and src1 each hold 10 words, MAX_BURST=8 -> sequence is marker0, 8 src0 words, marker1, 8 src1 words, marker0, 2 src0 words, marker1, 2 src1 words.
3. fifo_write_full held high for 5 cycles while in DATA -> no inc and no src_ready during the stall; the word is written after release, without duplication or loss.
4. Source 3 alone sends 3 words; the bench idles, then sends 3 more -> only one marker {3,0x3} in the total output.
5. rst_n asserted during HOLD -> all outputs 0 asynchronously; the next output after release is a marker.
6. (SL_ARB_PRIO0_EN) src1 bursting, src0 asserts valid mid-burst -> src1 is truncated after its current word; FIFO receives marker0 and the src0 words, then marker1 and the remaining src1 words.
